// File: rtl/exec_unit.sv
// exec_unit: small register-file execution unit. Single-cycle ALU ops write
// back at the accept edge; MUL/DIV/MOD iterate one bit per cycle in BUSY.
module exec_unit #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 4,
  localparam int unsigned IDXW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [IDXW-1:0]  in_dst,
  input  logic [IDXW-1:0]  in_src,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  output logic             wb_valid,
  output logic [IDXW-1:0]  wb_idx,
  output logic [WIDTH-1:0] wb_data,
  output logic             div_err,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;
  localparam logic [3:0] OP_MOD = 4'd10;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [3:0]       op_q, op_d;
  logic [IDXW-1:0]  dst_q, dst_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  // a: multiplicand / dividend-quotient shifter; b: multiplier / divisor;
  // acc: product accumulator / partial remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             wb_valid_q, wb_valid_d;
  logic             div_err_q, div_err_d;
  logic [IDXW-1:0]  wb_idx_q, wb_idx_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   rem_sh;
  logic             accept;

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign op_a     = regs_q[in_dst];
  assign op_b     = in_use_imm ? in_imm : regs_q[in_src];
  assign rem_sh   = {acc_q, a_q[WIDTH-1]};

  assign wb_valid = wb_valid_q;
  assign div_err  = div_err_q;
  assign wb_idx   = wb_idx_q;
  assign wb_data  = wb_data_q;
  assign rd_data  = regs_q[rd_idx];

  // Single-cycle ALU on the operands sampled at the accept edge
  always_comb begin
    alu_res = '0;
    case (in_op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = (op_b >= WIDTH'(WIDTH)) ? '0 : (op_a << op_b);
      OP_SHR:  alu_res = (op_b >= WIDTH'(WIDTH)) ? '0 : (op_a >> op_b);
      OP_MOV:  alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Next-state, datapath iteration and write-back selection
  always_comb begin
    state_d    = state_q;
    regs_d     = regs_q;
    op_d       = op_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    wb_valid_d = 1'b0;
    div_err_d  = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_op <= OP_MOV) begin
            regs_d[in_dst] = alu_res;
            wb_valid_d     = 1'b1;
            wb_idx_d       = in_dst;
            wb_data_d      = alu_res;
          end else if (in_op <= OP_MOD) begin
            state_d = BUSY;
            op_d    = in_op;
            dst_d   = in_dst;
            cnt_d   = '0;
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNTW'(WIDTH)) begin
          // Divide by zero falls out naturally: quotient all-ones, remainder A
          state_d        = IDLE;
          wb_valid_d     = 1'b1;
          wb_idx_d       = dst_q;
          wb_data_d      = (op_q == OP_DIV) ? a_q : acc_q;
          div_err_d      = (op_q != OP_MUL) && (b_q == '0);
          regs_d[dst_q]  = wb_data_d;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
          if (op_q == OP_MUL) begin
            acc_d = acc_q + (b_q[0] ? a_q : '0);
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end else if (rem_sh >= {1'b0, b_q}) begin
            acc_d = rem_sh[WIDTH-1:0] - b_q;
            a_d   = {a_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_q       <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      wb_valid_q <= 1'b0;
      div_err_q  <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      wb_valid_q <= wb_valid_d;
      div_err_q  <= div_err_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit (WIDTH=8, NREGS=4): stimulus pushes expected
// write-backs, a negedge monitor pops and compares each wb_valid pulse.
module tb_exec_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_dst;
  logic [1:0] in_src;
  logic [7:0] in_imm;
  logic       in_use_imm;
  logic       wb_valid;
  logic [1:0] wb_idx;
  logic [7:0] wb_data;
  logic       div_err;
  logic [1:0] rd_idx;
  logic [7:0] rd_data;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  exec_unit #(.WIDTH(8), .NREGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_dst     (in_dst),
    .in_src     (in_src),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .wb_valid   (wb_valid),
    .wb_idx     (wb_idx),
    .wb_data    (wb_data),
    .div_err    (div_err),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] idx, input logic [7:0] d, input logic err);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // Present one instruction, wait (bounded) for acceptance, record the expected write-back
  task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] src,
                       input logic [7:0] imm, input logic ui,
                       input bit wb, input logic [7:0] d, input logic err);
    int w;
    in_op      = op;
    in_dst     = dst;
    in_src     = src;
    in_imm     = imm;
    in_use_imm = ui;
    in_valid   = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) chk("issue_timeout", 0, 1);
    if (wb) push_exp(dst, d, err);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    tick();
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic chk_reg(input string name, input logic [1:0] idx, input int exp);
    rd_idx = idx;
    #1;
    chk(name, int'(rd_data), exp);
  endtask

  // Monitor: every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin : mon
    exp_t e;
    if (div_err && !wb_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL div_err_without_wb: got div_err=1 with wb_valid=0");
    end
    if (wb_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got idx=%0d data=%0d err=%0b, expected no write-back",
                 wb_idx, wb_data, div_err);
      end else begin
        e = sb_q.pop_front();
        if (wb_idx != e.idx || wb_data != e.data || div_err != e.err) begin
          n_fail++;
          $display("FAIL wb_compare: got idx=%0d data=%0d err=%0b, expected idx=%0d data=%0d err=%0b",
                   wb_idx, wb_data, div_err, e.idx, e.data, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_op      = '0;
    in_dst     = '0;
    in_src     = '0;
    in_imm     = '0;
    in_use_imm = 1'b0;
    rd_idx     = '0;
    tick();
    tick();
    // Reset state
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_div_err", int'(div_err), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_wb_idx", int'(wb_idx), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);

    // MOV r1,#200 ; ADD r1,#100 back-to-back
    issue(4'd7, 2'd1, 2'd0, 8'd200, 1'b1, 1'b1, 8'd200, 1'b0);
    issue(4'd0, 2'd1, 2'd0, 8'd100, 1'b1, 1'b1, 8'd44, 1'b0);
    chk_reg("rd_r1_add", 2'd1, 44);

    // MOV r2,#5 ; MOV r3,#7 ; SUB r2,r3 with in_ready held high
    chk("b2b_ready0", int'(in_ready), 1);
    issue(4'd7, 2'd2, 2'd0, 8'd5, 1'b1, 1'b1, 8'd5, 1'b0);
    chk("b2b_ready1", int'(in_ready), 1);
    issue(4'd7, 2'd3, 2'd0, 8'd7, 1'b1, 1'b1, 8'd7, 1'b0);
    chk("b2b_ready2", int'(in_ready), 1);
    issue(4'd1, 2'd2, 2'd3, 8'd0, 1'b0, 1'b1, 8'd254, 1'b0);
    chk("sub_wb_idx", int'(wb_idx), 2);
    chk("sub_wb_data", int'(wb_data), 254);

    // Logic ops on r2 (254)
    issue(4'd2, 2'd2, 2'd0, 8'h0F, 1'b1, 1'b1, 8'd14, 1'b0);
    issue(4'd3, 2'd2, 2'd0, 8'h30, 1'b1, 1'b1, 8'd62, 1'b0);
    issue(4'd4, 2'd2, 2'd0, 8'hFF, 1'b1, 1'b1, 8'd193, 1'b0);

    // r1=13 ; MUL r1,#11 with the next instruction held during BUSY
    issue(4'd7, 2'd1, 2'd0, 8'd13, 1'b1, 1'b1, 8'd13, 1'b0);
    in_op      = 4'd8;
    in_dst     = 2'd1;
    in_imm     = 8'd11;
    in_use_imm = 1'b1;
    in_valid   = 1'b1;
    push_exp(2'd1, 8'd143, 1'b0);
    tick();
    in_op  = 4'd7;
    in_dst = 2'd0;
    in_imm = 8'd100;
    push_exp(2'd0, 8'd100, 1'b0);
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("mul_busy_cycles", w, 9);
    chk("mul_wb_valid_at_9", int'(wb_valid), 1);
    chk("mul_wb_data_at_9", int'(wb_data), 143);
    tick();
    in_valid = 1'b0;
    chk_reg("rd_r1_mul", 2'd1, 143);
    chk_reg("rd_r0_held_mov", 2'd0, 100);

    // DIV / MOD including divide by zero
    issue(4'd9, 2'd0, 2'd0, 8'd7, 1'b1, 1'b1, 8'd14, 1'b0);
    issue(4'd7, 2'd0, 2'd0, 8'd100, 1'b1, 1'b1, 8'd100, 1'b0);
    issue(4'd10, 2'd0, 2'd0, 8'd7, 1'b1, 1'b1, 8'd2, 1'b0);
    issue(4'd9, 2'd0, 2'd0, 8'd0, 1'b1, 1'b1, 8'd255, 1'b1);
    issue(4'd7, 2'd0, 2'd0, 8'd100, 1'b1, 1'b1, 8'd100, 1'b0);
    issue(4'd10, 2'd0, 2'd0, 8'd0, 1'b1, 1'b1, 8'd100, 1'b1);
    drain();
    chk_reg("rd_r0_modz", 2'd0, 100);

    // Shift boundaries and NOP
    issue(4'd5, 2'd1, 2'd0, 8'd9, 1'b1, 1'b1, 8'd0, 1'b0);
    issue(4'd7, 2'd1, 2'd0, 8'd90, 1'b1, 1'b1, 8'd90, 1'b0);
    issue(4'd6, 2'd1, 2'd0, 8'd3, 1'b1, 1'b1, 8'd11, 1'b0);
    issue(4'd12, 2'd1, 2'd0, 8'd3, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    drain();
    chk_reg("rd_r1_after_nop", 2'd1, 11);

    // Reset during MUL aborts it
    issue(4'd7, 2'd3, 2'd0, 8'd50, 1'b1, 1'b1, 8'd50, 1'b0);
    in_op      = 4'd8;
    in_dst     = 2'd3;
    in_imm     = 8'd3;
    in_use_imm = 1'b1;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_busy_ready", int'(in_ready), 0);
    chk("rst_busy_wb", int'(wb_valid), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) chk_reg("after_rst_reg", 2'(i), 0);
    for (int i = 0; i < 12; i++) tick();
    issue(4'd0, 2'd3, 2'd0, 8'd1, 1'b1, 1'b1, 8'd1, 1'b0);

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the datapath and register width; legal values are 2 and above.
REQ-002 The parameter NREGS SHALL default to 4 and set the register-file depth; legal values are powers of two, 2 and above.
REQ-003 The derived value IDXW SHALL equal $clog2(NREGS) and SHALL NOT be overridable.
REQ-004 The port clk SHALL be an input of width 1: the single clock; all state updates on the rising edge.
REQ-005 The port rst SHALL be an input of width 1: reset, synchronous and active-high.
REQ-006 The port in_valid SHALL be an input of width 1: an instruction is presented.
REQ-007 The port in_ready SHALL be an output of width 1: the unit can accept an instruction this cycle.
REQ-008 The port in_op SHALL be an input of width 4: the opcode.
REQ-009 The port in_dst SHALL be an input of width IDXW: destination register, also the first operand.
REQ-010 The port in_src SHALL be an input of width IDXW: the source register index.
REQ-011 The port in_imm SHALL be an input of width WIDTH: the immediate operand.
REQ-012 The port in_use_imm SHALL be an input of width 1: when 1, the second operand is in_imm; when 0, it is regs[in_src].
REQ-013 The port wb_valid SHALL be an output of width 1: one-cycle pulse reporting a completed write-back.
REQ-014 The port wb_idx SHALL be an output of width IDXW: the register written.
REQ-015 The port wb_data SHALL be an output of width WIDTH: the value written.
REQ-016 The port div_err SHALL be an output of width 1: pulses together with wb_valid on DIV or MOD by zero.
REQ-017 The port rd_idx SHALL be an input of width IDXW: debug read index.
REQ-018 The port rd_data SHALL be an output of width WIDTH: combinational regs[rd_idx].

Function
REQ-019 An instruction SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands A=regs[in_dst] and B (per REQ-012) SHALL be sampled at that edge.
REQ-020 The state machine SHALL have the states IDLE and BUSY; in_ready SHALL be 1 only in IDLE while rst=0.
REQ-021 The opcodes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MOV (result B), 8 MUL, 9 DIV, 10 MOD (unsigned); opcodes 11-15 SHALL be NOP: accepted, no write, no wb_valid.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; MUL SHALL keep the low WIDTH bits of the product.
REQ-023 SHL and SHR SHALL return 0 when B>=WIDTH.
REQ-024 Opcodes 0-7 SHALL be single-cycle: at the accept edge, regs[in_dst] is written and wb_valid/wb_idx/wb_data are registered, so they are visible in the next cycle; the state SHALL stay IDLE.
REQ-025 Back-to-back single-cycle instructions SHALL be accepted every cycle, each reading register values already updated by the previous instruction.
REQ-026 For MUL, DIV and MOD, the unit SHALL enter BUSY at the accept edge.
REQ-027 In BUSY, the unit SHALL iterate one bit per cycle: shift-add for MUL, restoring division for DIV and MOD.
REQ-028 The unit SHALL write the register and pulse wb_valid at edge N+WIDTH+1 when accepted at edge N, then return to IDLE.
REQ-029 in_ready SHALL be low throughout BUSY.
REQ-030 A held in_valid during BUSY SHALL NOT be accepted and SHALL NOT be lost; its instruction fields SHALL stay stable until accepted.
REQ-031 DIV by zero SHALL return all-ones, and MOD by zero SHALL return A; both SHALL take normal latency and pulse div_err with wb_valid.
REQ-032 wb_valid and div_err SHALL be high for exactly one cycle per write-back.
REQ-033 wb_idx and wb_data SHALL hold their last values when wb_valid is 0.

Reset
REQ-034 While rst=1, all registers SHALL clear to 0, the state SHALL go to IDLE, wb_valid, div_err, wb_idx and wb_data SHALL be 0, and in_ready SHALL be 0.
REQ-035 rst asserted during BUSY SHALL abort the operation with no write-back; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=8, NREGS=4)
REQ-036 The bench SHALL cover MOV r1,#200 then ADD r1,#100 on consecutive cycles -> wb_data 200, then 44; rd_data(r1)=44.
REQ-037 The bench SHALL cover MOV r2,#5, MOV r3,#7, SUB r2,r3 back-to-back -> in_ready constant 1; final wb_data 254, wb_idx 2.
REQ-038 The bench SHALL cover r1=13, MUL r1,#11 with in_valid held for the next instruction -> in_ready low for 9 cycles; wb_valid 9 cycles after accept with 143; the held instruction is accepted only after.
REQ-039 The bench SHALL cover r0=100, DIV r0,#7 -> 14; MOD with r0=100, #7 -> 2; DIV r0,#0 -> 255 with div_err=1.
REQ-040 The bench SHALL cover SHL r1,#9 -> 0; opcode 12 -> no wb_valid and no register change.
REQ-041 The bench SHALL cover rst pulsed at cycle 4 of a MUL -> no wb_valid; all rd_data 0; in_ready 1 in the cycle after rst falls.
